wb_egress_packer: RTL and testbench

- Wishbone-side command/data packer that sits directly upstream of the egress FIFO (wb_clk domain).
- Turns Wishbone cycles into tagged FIFO words:
  - one header word per transaction (start address, direction, burst length);
  - for writes, one data word per beat.
- Generates write acks and burst-length bookkeeping.
- Read data returns on the ingress path; this block only tracks read-beat completion so it can accept the next command.

---
 rtl/wb_egress_pkg.sv | 43 ++++
 rtl/wb_egress_packer_if.sv | 37 +++
 rtl/wb_egress_packer.sv | 130 +++++++++++++
 tb/tb_wb_egress_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_egress_pkg.sv
// Shared definitions for the Wishbone egress packer: FIFO word tags,
// Wishbone cycle/burst type codes, FSM state encoding and the
// burst-length decode helpers.
package wb_egress_pkg;

  localparam logic [1:0] TAG_HDR = 2'b01;
  localparam logic [1:0] TAG_DAT = 2'b10;
  localparam logic [1:0] TAG_ABT = 2'b11;

  localparam logic [2:0] CTI_CLASSIC    = 3'b000;
  localparam logic [2:0] CTI_INCR       = 3'b010;
  localparam logic [2:0] CTI_ENDOFBURST = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_RWAIT = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  // Only wrapping incrementing bursts are carried as one transaction;
  // classic, end-of-burst and linear incr beats each get their own header.
  function automatic logic [1:0] blen_code(input logic [2:0] cti, input logic [1:0] bte);
    return (cti == CTI_INCR) ? bte : 2'b00;
  endfunction

  function automatic logic [4:0] blen_beats(input logic [1:0] code);
    logic [4:0] beats;
    case (code)
      2'b00:   beats = 5'd1;
      2'b01:   beats = 5'd4;
      2'b10:   beats = 5'd8;
      default: beats = 5'd16;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/wb_egress_packer_if.sv
// Bus bundle for the egress packer: pipelined Wishbone slave signals,
// the read-beat completion pulse from the ingress path, the egress FIFO
// write port and the busy flag.
//   slave  : packer view (Wishbone in, FIFO push out)
//   master : upstream/bench view
interface wb_egress_packer_if #(
  parameter int ADR_W  = 24,
  parameter int FIFO_W = 38
);
  logic [ADR_W-1:0]  wb_adr_i;
  logic [31:0]       wb_dat_i;
  logic [3:0]        wb_sel_i;
  logic              wb_we_i;
  logic [2:0]        wb_cti_i;
  logic [1:0]        wb_bte_i;
  logic              wb_stb_i;
  logic              wb_cyc_i;
  logic              wb_stall_o;
  logic              wb_ack_o;
  logic              rd_ack_i;
  logic              egress_fifo_full;
  logic              egress_fifo_we;
  logic [FIFO_W-1:0] egress_fifo_dat;
  logic              busy_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i,
    input  wb_stb_i, wb_cyc_i, rd_ack_i, egress_fifo_full,
    output wb_stall_o, wb_ack_o, egress_fifo_we, egress_fifo_dat, busy_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cti_i, wb_bte_i,
    output wb_stb_i, wb_cyc_i, rd_ack_i, egress_fifo_full,
    input  wb_stall_o, wb_ack_o, egress_fifo_we, egress_fifo_dat, busy_o
  );
endinterface

// File: rtl/wb_egress_packer.sv
// Wishbone-to-egress-FIFO packer. Each Wishbone transaction produces one
// tagged header word; write beats each produce a tagged data word and are
// acked in the cycle they are pushed. Reads only push the header and then
// count rd_ack_i pulses from the ingress path until the burst completes.
// Ports:
//   wb_clk, wb_rst : clock, asynchronous active-high reset
//   bus (slave)    : Wishbone slave, rd_ack_i, egress FIFO push, busy_o
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a request; pushes the header when FIFO has room
// ST_WDATA | write burst in progress; one DAT push + ack per beat
// ST_RWAIT | read burst in progress; counts rd_ack_i beats
// ST_ABORT | write cycle dropped early; push ABT word then return to idle
module wb_egress_packer
  import wb_egress_pkg::*;
#(
  parameter int ADR_W  = 24,
  parameter int FIFO_W = 38
) (
  input logic             wb_clk,
  input logic             wb_rst,
  wb_egress_packer_if.slave bus
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [4:0]        blen_q, blen_d;

  logic              req;
  logic              last_beat;
  logic [1:0]        code;
  logic [35:0]       hdr_pl;
  logic              stall;
  logic              ack;
  logic              push;
  logic [FIFO_W-1:0] word;

  assign req       = bus.wb_cyc_i & bus.wb_stb_i;
  assign last_beat = ({1'b0, cnt_q} == (blen_q - 5'd1));
  assign code      = blen_code(bus.wb_cti_i, bus.wb_bte_i);

  always_comb begin
    hdr_pl              = '0;
    hdr_pl[35]          = bus.wb_we_i;
    hdr_pl[34:33]       = code;
    hdr_pl[ADR_W-1:0]   = bus.wb_adr_i;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      blen_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blen_q  <= blen_d;
    end
  end

  // Transfer direction is not stored separately: it is implied by which
  // burst state the header sends us to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blen_d  = blen_q;
    stall   = 1'b0;
    ack     = 1'b0;
    push    = 1'b0;
    word    = '0;
    case (state_q)
      ST_IDLE: begin
        stall = req;
        if (req && !bus.egress_fifo_full) begin
          push    = 1'b1;
          word    = {TAG_HDR, hdr_pl};
          blen_d  = blen_beats(code);
          cnt_d   = '0;
          state_d = bus.wb_we_i ? ST_WDATA : ST_RWAIT;
        end
      end
      ST_WDATA: begin
        if (!bus.wb_cyc_i) begin
          state_d = ST_ABORT;
        end else if (bus.wb_stb_i) begin
          if (bus.egress_fifo_full) begin
            stall = 1'b1;
          end else begin
            push  = 1'b1;
            ack   = 1'b1;
            word  = {TAG_DAT, bus.wb_sel_i, bus.wb_dat_i};
            cnt_d = cnt_q + 4'd1;
            if (last_beat || (bus.wb_cti_i == CTI_ENDOFBURST)) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_ABORT: begin
        stall = 1'b1;
        if (!bus.egress_fifo_full) begin
          push    = 1'b1;
          word    = {TAG_ABT, 36'd0};
          state_d = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        // The cycle may already be gone; beats are counted to the burst length regardless.
        stall = !bus.rd_ack_i;
        if (bus.rd_ack_i) begin
          cnt_d = cnt_q + 4'd1;
          if (last_beat) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks out of the
  // combinational IDLE path before the register clears.
  assign bus.wb_stall_o      = stall & ~wb_rst;
  assign bus.wb_ack_o        = ack & ~wb_rst;
  assign bus.egress_fifo_we  = push & ~wb_rst;
  assign bus.egress_fifo_dat = wb_rst ? '0 : word;
  assign bus.busy_o          = (state_q != ST_IDLE) & ~wb_rst;

endmodule

// File: tb/tb_wb_egress_packer.sv
module tb_wb_egress_packer;
  import wb_egress_pkg::*;

  logic wb_clk;
  logic wb_rst;

  wb_egress_packer_if #(.ADR_W(24), .FIFO_W(38)) bus ();

  wb_egress_packer #(.ADR_W(24), .FIFO_W(38)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus.slave)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_err    = 0;
  int ack_seen = 0;
  logic [37:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] hdr_word(input logic we, input logic [1:0] c, input logic [23:0] adr);
    return {2'b01, we, c, 9'd0, adr};
  endfunction

  // Scoreboard monitor: every FIFO push is popped against the expected queue.
  always @(negedge wb_clk) begin
    logic [37:0] e;
    if (bus.wb_ack_o) ack_seen++;
    if (bus.egress_fifo_we) begin
      chk("push_while_full", {63'd0, bus.egress_fifo_full}, 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_push: got %h expected no push at %0t", bus.egress_fifo_dat, $time);
      end else begin
        e = exp_q.pop_front();
        chk("fifo_word", {26'd0, bus.egress_fifo_dat}, {26'd0, e});
      end
    end
  end

  task automatic idle_bus(input int n);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  // Called at posedge+1. Leaves the bus driven on normal completion.
  task automatic wr_txn(input logic [23:0] adr, input logic [2:0] cti, input logic [1:0] bte,
                        input logic [1:0] exp_code, input int nbeats, input logic [31:0] dat_base,
                        input logic [3:0] sel, input int full_after, input int drop_after);
    bit got;
    exp_q.push_back(hdr_word(1'b1, exp_code, adr));
    bus.wb_adr_i = adr;
    bus.wb_cti_i = cti;
    bus.wb_bte_i = bte;
    bus.wb_we_i  = 1'b1;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat_base;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(negedge wb_clk);
    chk("hdr_push_now", {63'd0, bus.egress_fifo_we}, 64'd1);
    chk("hdr_stall", {63'd0, bus.wb_stall_o}, 64'd1);
    chk("hdr_no_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    @(posedge wb_clk); #1;
    for (int b = 0; b < nbeats; b++) begin
      if (b == drop_after) begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        exp_q.push_back({2'b11, 36'd0});
        @(negedge wb_clk);
        @(negedge wb_clk);
        chk("abt_push", {63'd0, bus.egress_fifo_we}, 64'd1);
        chk("abt_stall", {63'd0, bus.wb_stall_o}, 64'd1);
        @(negedge wb_clk);
        chk("abt_idle", {63'd0, bus.busy_o}, 64'd0);
        @(posedge wb_clk); #1;
        return;
      end
      bus.wb_dat_i = dat_base + 32'(b);
      exp_q.push_back({2'b10, sel, dat_base + 32'(b)});
      if (b == full_after) begin
        bus.egress_fifo_full = 1'b1;
        repeat (3) begin
          @(negedge wb_clk);
          chk("full_stall", {63'd0, bus.wb_stall_o}, 64'd1);
          chk("full_no_ack", {63'd0, bus.wb_ack_o}, 64'd0);
        end
        @(posedge wb_clk); #1;
        bus.egress_fifo_full = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge wb_clk);
        if (bus.wb_ack_o) begin
          got = 1'b1;
          break;
        end
      end
      chk("beat_ack", {63'd0, got}, 64'd1);
      @(posedge wb_clk); #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the bus idle.
  task automatic rd_txn(input logic [23:0] adr, input logic [1:0] bte, input logic [1:0] exp_code,
                        input int nbeats, input int rst_at);
    exp_q.push_back(hdr_word(1'b0, exp_code, adr));
    bus.wb_adr_i = adr;
    bus.wb_cti_i = CTI_INCR;
    bus.wb_bte_i = bte;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(negedge wb_clk);
    chk("rd_hdr_push", {63'd0, bus.egress_fifo_we}, 64'd1);
    chk("rd_hdr_stall", {63'd0, bus.wb_stall_o}, 64'd1);
    @(posedge wb_clk); #1;
    for (int i = 0; i < nbeats; i++) begin
      if (i == rst_at) begin
        wb_rst = 1'b1;
        #1;
        chk("rst_stall", {63'd0, bus.wb_stall_o}, 64'd0);
        chk("rst_ack", {63'd0, bus.wb_ack_o}, 64'd0);
        chk("rst_we", {63'd0, bus.egress_fifo_we}, 64'd0);
        chk("rst_dat", {26'd0, bus.egress_fifo_dat}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        @(posedge wb_clk); #1;
        wb_rst = 1'b0;
        return;
      end
      @(negedge wb_clk);
      chk("rd_wait_stall", {63'd0, bus.wb_stall_o}, 64'd1);
      chk("rd_wait_busy", {63'd0, bus.busy_o}, 64'd1);
      @(posedge wb_clk); #1;
      bus.rd_ack_i = 1'b1;
      @(negedge wb_clk);
      chk("rd_ack_stall", {63'd0, bus.wb_stall_o}, 64'd0);
      chk("rd_no_wb_ack", {63'd0, bus.wb_ack_o}, 64'd0);
      @(posedge wb_clk); #1;
      bus.rd_ack_i = 1'b0;
      if (i == nbeats - 1) begin
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
      end
    end
    @(negedge wb_clk);
    chk("rd_done_busy", {63'd0, bus.busy_o}, 64'd0);
    @(posedge wb_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst               = 1'b1;
    bus.wb_adr_i         = '0;
    bus.wb_dat_i         = '0;
    bus.wb_sel_i         = '0;
    bus.wb_we_i          = 1'b0;
    bus.wb_cti_i         = '0;
    bus.wb_bte_i         = '0;
    bus.wb_stb_i         = 1'b0;
    bus.wb_cyc_i         = 1'b0;
    bus.rd_ack_i         = 1'b0;
    bus.egress_fifo_full = 1'b0;
    #2;
    chk("reset_stall", {63'd0, bus.wb_stall_o}, 64'd0);
    chk("reset_ack", {63'd0, bus.wb_ack_o}, 64'd0);
    chk("reset_we", {63'd0, bus.egress_fifo_we}, 64'd0);
    chk("reset_busy", {63'd0, bus.busy_o}, 64'd0);
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    idle_bus(2);

    // Classic single write.
    wr_txn(24'h000010, CTI_CLASSIC, BTE_LINEAR, 2'b00, 1, 32'hDEADBEEF, 4'hF, -1, -1);
    idle_bus(2);
    chk("classic_idle", {63'd0, bus.busy_o}, 64'd0);

    // wrap8 write with a 3-cycle full window after beat 4.
    wr_txn(24'h000100, CTI_INCR, BTE_WRAP8, 2'b10, 8, 32'h1000_0000, 4'hC, 4, -1);
    idle_bus(2);

    // wrap4 read.
    rd_txn(24'h000020, BTE_WRAP4, 2'b01, 4, -1);
    idle_bus(2);

    // wrap16 write dropped after 5 beats.
    wr_txn(24'h000200, CTI_INCR, BTE_WRAP16, 2'b11, 16, 32'h2000_0000, 4'h5, -1, 5);
    idle_bus(2);

    // Linear incr: each beat is its own single-beat transaction.
    wr_txn(24'h000040, CTI_INCR, BTE_LINEAR, 2'b00, 1, 32'hCAFE_0000, 4'hF, -1, -1);
    wr_txn(24'h000041, CTI_INCR, BTE_LINEAR, 2'b00, 1, 32'hCAFE_0001, 4'hF, -1, -1);
    wr_txn(24'h000042, CTI_ENDOFBURST, BTE_LINEAR, 2'b00, 1, 32'hCAFE_0002, 4'hF, -1, -1);
    idle_bus(2);

    // rd_ack_i outside a read is ignored.
    bus.rd_ack_i = 1'b1;
    @(negedge wb_clk);
    chk("stray_rdack_busy", {63'd0, bus.busy_o}, 64'd0);
    @(posedge wb_clk); #1;
    bus.rd_ack_i = 1'b0;
    @(negedge wb_clk);
    chk("stray_rdack_busy2", {63'd0, bus.busy_o}, 64'd0);
    @(posedge wb_clk); #1;

    // Reset during an 8-beat read, then a new write straight after release.
    rd_txn(24'h000300, BTE_WRAP8, 2'b10, 8, 3);
    wr_txn(24'h000055, CTI_CLASSIC, BTE_LINEAR, 2'b00, 1, 32'h12345678, 4'h3, -1, -1);
    idle_bus(3);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("ack_total", 64'(ack_seen), 64'd18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
